// File: rtl/quickq_arbiter_pkg.sv
// Shared types for the quick-queue arbiter: FSM state and queue operation encodings.
package quickq_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

  typedef enum logic {
    QqEnq = 1'b0,
    QqDeq = 1'b1
  } qq_op_e;

endpackage

// File: rtl/quickq_arbiter_rr.sv
// Rotating-priority picker: first requester at or after the pointer wins; pointer moves
// past the winner whenever en_i accepts the grant.
module quickq_arbiter_rr
  import quickq_arbiter_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N-1:0]   req_i,
  input  logic           en_i,
  output logic           valid_o,
  output logic [N-1:0]   gnt_o,
  output logic [IdW-1:0] idx_o
);

  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW:0]   sum;
  logic [IdW-1:0] cand;

  // Walk from farthest to nearest so the candidate closest to the pointer wins last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (IdW + 1)'(k);
      if (sum >= (IdW + 1)'(N)) begin
        sum = sum - (IdW + 1)'(N);
      end
      cand = sum[IdW-1:0];
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
    gnt_o = '0;
    if (valid_o) begin
      gnt_o[idx_o] = 1'b1;
    end
    ptr_d = (idx_o == IdW'(N - 1)) ? '0 : idx_o + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (en_i && valid_o) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/quickq_arbiter.sv
// Round-robin front end sharing one quick-queue between N requesters, one op in flight.
// Optional per-requester grant statistics are enabled with QQ_ARB_STATS_EN.
module quickq_arbiter
  import quickq_arbiter_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned W      = 32,
  parameter int unsigned D      = 4,
  parameter int unsigned OP_LAT = 3,
  localparam int unsigned IdW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
`ifdef QQ_ARB_STATS_EN
  output logic [N*16-1:0] grant_cnt_o,
`endif
  input  logic [N-1:0]   req_valid_i,
  input  logic [N-1:0]   req_op_i,
  input  logic [N*W-1:0] req_lt_i,
  input  logic [N*W-1:0] req_rt_i,
  output logic [N-1:0]   req_ready_o,
  output logic           resp_valid_o,
  input  logic           resp_ready_i,
  output logic [IdW-1:0] resp_id_o,
  output logic           resp_err_o,
  output logic [W-1:0]   resp_lt_o,
  output logic [W-1:0]   resp_rt_o,
  output logic           qq_enq_o,
  output logic           qq_deq_o,
  output logic [W-1:0]   qq_lt_o,
  output logic [W-1:0]   qq_rt_o,
  output logic [31:0]    qq_size_o,
  input  logic [W-1:0]   qq_lt_i,
  input  logic [W-1:0]   qq_rt_i
);

  localparam int unsigned OccW = $clog2(D + 1);
  localparam int unsigned CntW = (OP_LAT > 1) ? $clog2(OP_LAT) : 1;

  arb_state_e     state_q, state_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  qq_op_e         op_q, op_d;
  logic [IdW-1:0] id_q, id_d;
  logic [W-1:0]   lt_q, lt_d, rt_q, rt_d;
  logic           err_q, err_d;
  logic [W-1:0]   resp_lt_q, resp_lt_d, resp_rt_q, resp_rt_d;

  logic           arb_valid, grant_en;
  logic [N-1:0]   arb_gnt;
  logic [IdW-1:0] arb_idx;
  logic [W-1:0]   sel_lt, sel_rt;
  logic           sel_op;

  quickq_arbiter_rr #(
    .N   (N),
    .IdW (IdW)
  ) u_rr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_valid_i),
    .en_i    (grant_en),
    .valid_o (arb_valid),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx)
  );

  always_comb begin
    sel_lt = '0;
    sel_rt = '0;
    sel_op = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (arb_idx == IdW'(k)) begin
        sel_lt = req_lt_i[k*W +: W];
        sel_rt = req_rt_i[k*W +: W];
        sel_op = req_op_i[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    occ_d     = occ_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    id_d      = id_q;
    lt_d      = lt_q;
    rt_d      = rt_q;
    err_d     = err_q;
    resp_lt_d = resp_lt_q;
    resp_rt_d = resp_rt_q;
    grant_en  = 1'b0;
    qq_enq_o  = 1'b0;
    qq_deq_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_en = 1'b1;
          op_d     = qq_op_e'(sel_op);
          id_d     = arb_idx;
          lt_d     = sel_lt;
          rt_d     = sel_rt;
          // Rejected ops never reach the queue; answer straight from here.
          if ((qq_op_e'(sel_op) == QqEnq && occ_q == OccW'(D)) ||
              (qq_op_e'(sel_op) == QqDeq && occ_q == '0)) begin
            err_d     = 1'b1;
            resp_lt_d = '0;
            resp_rt_d = '0;
            state_d   = StResp;
          end else begin
            err_d   = 1'b0;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (op_q == QqEnq) begin
          qq_enq_o = 1'b1;
          occ_d    = occ_q + 1'b1;
        end else begin
          qq_deq_o = 1'b1;
          occ_d    = occ_q - 1'b1;
        end
        cnt_d   = CntW'(OP_LAT - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          resp_lt_d = qq_lt_i;
          resp_rt_d = qq_rt_i;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (resp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      occ_q     <= '0;
      cnt_q     <= '0;
      op_q      <= QqEnq;
      id_q      <= '0;
      lt_q      <= '0;
      rt_q      <= '0;
      err_q     <= 1'b0;
      resp_lt_q <= '0;
      resp_rt_q <= '0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      id_q      <= id_d;
      lt_q      <= lt_d;
      rt_q      <= rt_d;
      err_q     <= err_d;
      resp_lt_q <= resp_lt_d;
      resp_rt_q <= resp_rt_d;
    end
  end

  always_comb begin
    req_ready_o  = (state_q == StIdle) ? arb_gnt : '0;
    resp_valid_o = (state_q == StResp);
    resp_id_o    = id_q;
    resp_err_o   = err_q;
    resp_lt_o    = resp_lt_q;
    resp_rt_o    = resp_rt_q;
    qq_lt_o      = (state_q == StIssue || state_q == StWait) ? lt_q : '0;
    qq_rt_o      = (state_q == StIssue || state_q == StWait) ? rt_q : '0;
    qq_size_o    = 32'(occ_q);
  end

`ifdef QQ_ARB_STATS_EN
  for (genvar i = 0; i < N; i++) begin : g_stats
    logic [15:0] cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (req_ready_o[i] && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign grant_cnt_o[i*16 +: 16] = cnt_q;
  end
`endif

endmodule
